// File: rtl/aes_post_intel_if.sv
// ---------------------------------------------------------------------------
// aes_post_intel_if
//   Bundle between the AES round pipeline / downstream consumer and the
//   aes_post_intel output stage.
//   master : the environment (drives AES words and downstream ready)
//   slave  : aes_post_intel (drives results, feedback IV and status)
//   Signals:
//     ivalid/icipher/idata/ichain/ikeep/ilast : AES word and side-band
//     iready                                  : downstream accepts
//     odata/okeep/olast/ovalid                : buffered result word
//     oalmostfull                             : upstream must stop issuing
//     ofeedbackiv/ofeedbackvalid              : CBC-encrypt chain feedback
//     ooverflow                               : sticky drop indicator
//     oblocks                                 : delivered-word counter
// ---------------------------------------------------------------------------
interface aes_post_intel_if #(
  parameter int N_PIPES = 4
) ();
  logic                     ivalid;
  logic [N_PIPES*128-1:0]   icipher;
  logic [N_PIPES*128-1:0]   idata;
  logic [N_PIPES*128-1:0]   ichain;
  logic [N_PIPES*16-1:0]    ikeep;
  logic                     ilast;
  logic                     iready;

  logic                     oalmostfull;
  logic [N_PIPES*128-1:0]   odata;
  logic [N_PIPES*16-1:0]    okeep;
  logic                     olast;
  logic                     ovalid;
  logic [127:0]             ofeedbackiv;
  logic                     ofeedbackvalid;
  logic                     ooverflow;
  logic [31:0]              oblocks;

  modport master (
    output ivalid, icipher, idata, ichain, ikeep, ilast, iready,
    input  oalmostfull, odata, okeep, olast, ovalid,
           ofeedbackiv, ofeedbackvalid, ooverflow, oblocks
  );

  modport slave (
    input  ivalid, icipher, idata, ichain, ikeep, ilast, iready,
    output oalmostfull, odata, okeep, olast, ovalid,
           ofeedbackiv, ofeedbackvalid, ooverflow, oblocks
  );
endinterface

// File: rtl/aes_post_intel.sv
// ---------------------------------------------------------------------------
// aes_post_intel
//   Output stage behind the AES round pipeline. Each incoming word is
//   combined with its side-band payload/chain word according to MODE and
//   OPERATION, registered once, then buffered in a first-word-fall-through
//   FIFO. The AES pipeline cannot stall, so the FIFO raises a registered
//   almost-full flag early enough to cover the words still in flight.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous active-high reset
//     bus   : aes_post_intel_if.slave (AES word in, result out, status)
// ---------------------------------------------------------------------------
module aes_post_intel #(
  parameter int N_PIPES    = 4,
  parameter int MODE       = 0,   // 0 ECB, 1 CTR, 2 CBC
  parameter int OPERATION  = 0,   // 0 encrypt, 1 decrypt
  parameter int FIFO_DEPTH = 32,
  parameter int PIPE_SLACK = 16
) (
  input  logic             clk,
  input  logic             reset,
  aes_post_intel_if.slave  bus
);

  localparam int DW = N_PIPES * 128;
  localparam int KW = N_PIPES * 16;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DW + KW + 1;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(FIFO_DEPTH - PIPE_SLACK);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  localparam bit XOR_DATA  = (MODE == 1);
  localparam bit XOR_CHAIN = (MODE == 2) && (OPERATION == 1);
  localparam bit CBC_ENC   = (MODE == 2) && (OPERATION == 0);

  // Stage 1 registers
  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_word_q,  s1_word_d;
  logic [KW-1:0] s1_keep_q,  s1_keep_d;
  logic          s1_last_q,  s1_last_d;

  // CBC-encrypt feedback
  logic          fb_valid_q, fb_valid_d;
  logic [127:0]  fb_iv_q,    fb_iv_d;

  // FIFO control; pointers carry one extra bit so full and empty differ
  logic [AW:0]   wr_ptr_q,   wr_ptr_d;
  logic [AW:0]   rd_ptr_q,   rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          af_q,       af_d;
  logic [31:0]   blocks_q,   blocks_d;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [EW-1:0] head_w;
  logic [DW-1:0] word_w;
  logic [AW:0]   count_w;
  logic          empty_w;
  logic          full_w;
  logic          pop_w;
  logic          wr_en_w;

  // Mode-dependent combine of cipher output with payload / chain word
  always_comb begin
    word_w = bus.icipher;
    if (XOR_DATA) begin
      word_w = word_w ^ bus.idata;
    end
    if (XOR_CHAIN) begin
      word_w = word_w ^ bus.ichain;
    end
  end

  always_comb begin
    count_w = wr_ptr_q - rd_ptr_q;
    empty_w = (count_w == '0);
    full_w  = (count_w == DEPTH_C);
    pop_w   = !empty_w && bus.iready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    wr_en_w = s1_valid_q && (!full_w || pop_w);

    s1_valid_d = bus.ivalid;
    s1_word_d  = s1_word_q;
    s1_keep_d  = s1_keep_q;
    s1_last_d  = s1_last_q;
    if (bus.ivalid) begin
      s1_word_d = word_w;
      s1_keep_d = bus.ikeep;
      s1_last_d = bus.ilast;
    end

    // Feedback is taken straight from the input, independent of the FIFO
    fb_valid_d = CBC_ENC && bus.ivalid;
    fb_iv_d    = fb_iv_q;
    if (CBC_ENC && bus.ivalid) begin
      fb_iv_d = bus.icipher[DW-1 -: 128];
    end

    wr_ptr_d = wr_ptr_q;
    if (wr_en_w) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
    end

    overflow_d = overflow_q || (s1_valid_q && full_w && !pop_w);
    af_d       = (count_w >= AF_C);
    blocks_d   = blocks_q + 32'(pop_w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s1_keep_q  <= '0;
      s1_last_q  <= 1'b0;
      fb_valid_q <= 1'b0;
      fb_iv_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      af_q       <= 1'b0;
      blocks_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_word_q  <= s1_word_d;
      s1_keep_q  <= s1_keep_d;
      s1_last_q  <= s1_last_d;
      fb_valid_q <= fb_valid_d;
      fb_iv_q    <= fb_iv_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      af_q       <= af_d;
      blocks_q   <= blocks_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (wr_en_w) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= {s1_word_q, s1_keep_q, s1_last_q};
    end
  end

  // First-word-fall-through head; forced to zero while empty
  assign head_w = fifo_mem[rd_ptr_q[AW-1:0]];

  assign bus.ovalid         = !empty_w;
  assign bus.odata          = empty_w ? '0   : head_w[EW-1 -: DW];
  assign bus.okeep          = empty_w ? '0   : head_w[KW:1];
  assign bus.olast          = empty_w ? 1'b0 : head_w[0];
  assign bus.oalmostfull    = af_q;
  assign bus.ooverflow      = overflow_q;
  assign bus.oblocks        = blocks_q;
  assign bus.ofeedbackvalid = fb_valid_q;
  assign bus.ofeedbackiv    = fb_iv_q;

endmodule

// File: tb/tb_aes_post_intel.sv
// ---------------------------------------------------------------------------
// tb_aes_post_intel
//   Four instances (ECB, CTR, CBC-enc, CBC-dec) receive identical stimulus.
//   A vector table covers the per-mode datapath; hand-written sequences
//   cover almost-full/overflow, full FIFO with simultaneous pop and write,
//   and reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_aes_post_intel;
  localparam int NP = 4;
  localparam int DW = NP * 128;
  localparam int KW = NP * 16;

  localparam int M_ECB  = 0;
  localparam int M_CTR  = 1;
  localparam int M_CBCE = 2;
  localparam int M_CBCD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ivalid, ilast, iready;
  logic [DW-1:0] icipher, idata, ichain;
  logic [KW-1:0] ikeep;

  logic [3:0]    ovalid_a, olast_a, oaf_a, ofbv_a, oovf_a;
  logic [DW-1:0] odata_a   [4];
  logic [KW-1:0] okeep_a   [4];
  logic [127:0]  ofbiv_a   [4];
  logic [31:0]   oblocks_a [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      aes_post_intel_if #(.N_PIPES(NP)) u_if ();
      assign u_if.ivalid  = ivalid;
      assign u_if.icipher = icipher;
      assign u_if.idata   = idata;
      assign u_if.ichain  = ichain;
      assign u_if.ikeep   = ikeep;
      assign u_if.ilast   = ilast;
      assign u_if.iready  = iready;
      assign ovalid_a[gi]  = u_if.ovalid;
      assign olast_a[gi]   = u_if.olast;
      assign oaf_a[gi]     = u_if.oalmostfull;
      assign ofbv_a[gi]    = u_if.ofeedbackvalid;
      assign oovf_a[gi]    = u_if.ooverflow;
      assign odata_a[gi]   = u_if.odata;
      assign okeep_a[gi]   = u_if.okeep;
      assign ofbiv_a[gi]   = u_if.ofeedbackiv;
      assign oblocks_a[gi] = u_if.oblocks;

      aes_post_intel #(
        .N_PIPES   (NP),
        .MODE      ((gi == 0) ? 0 : (gi == 1) ? 1 : 2),
        .OPERATION ((gi == 3) ? 1 : 0),
        .FIFO_DEPTH(32),
        .PIPE_SLACK(16)
      ) u_dut (
        .clk  (clk),
        .reset(rst),
        .bus  (u_if)
      );
    end
  endgenerate

  typedef struct {
    logic [DW-1:0]      c;
    logic [DW-1:0]      d;
    logic [DW-1:0]      ch;
    logic [KW-1:0]      k;
    logic               l;
    logic [3:0][DW-1:0] exp;
    logic [127:0]       fbiv;
  } vec_t;

  vec_t vecs [4];
  int   checks   = 0;
  int   failures = 0;
  int   exp_blocks;
  int   rd_idx;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data is deliberately scrambled while ivalid=0; the DUT must ignore it
  task automatic idle();
    ivalid  = 1'b0;
    icipher = {16{$urandom}};
    idata   = {16{$urandom}};
    ichain  = {16{$urandom}};
    ikeep   = {2{$urandom}};
    ilast   = 1'($urandom);
  endtask

  task automatic send(input logic [DW-1:0] c, input logic [DW-1:0] d,
                      input logic [DW-1:0] ch, input logic [KW-1:0] k, input logic l);
    ivalid  = 1'b1;
    icipher = c;
    idata   = d;
    ichain  = ch;
    ikeep   = k;
    ilast   = l;
  endtask

  // Numbered word: lane0 carries the index, other lanes zero, so every mode
  // produces the same result (payload and chain are zero).
  task automatic send_idx(input int i);
    send({384'd0, 128'(i)}, '0, '0, {KW{1'b1}}, ((i % 2) == 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector table ----------------
    vecs[0].c  = {64{8'hFF}};
    vecs[0].d  = {64{8'h0F}};
    vecs[0].ch = '0;
    vecs[0].k  = {KW{1'b1}};
    vecs[0].l  = 1'b1;
    vecs[0].exp[M_ECB]  = {64{8'hFF}};
    vecs[0].exp[M_CTR]  = {64{8'hF0}};
    vecs[0].exp[M_CBCE] = {64{8'hFF}};
    vecs[0].exp[M_CBCD] = {64{8'hFF}};
    vecs[0].fbiv = {16{8'hFF}};

    vecs[1].c  = {{16{8'hA5}}, 128'h3, 128'h2, 128'h1};
    vecs[1].d  = {128'h0, 128'h0, 128'hFF, 128'h0};
    vecs[1].ch = '0;
    vecs[1].k  = 64'h0123_4567_89AB_CDEF;
    vecs[1].l  = 1'b0;
    vecs[1].exp[M_ECB]  = {{16{8'hA5}}, 128'h3, 128'h2, 128'h1};
    vecs[1].exp[M_CTR]  = {{16{8'hA5}}, 128'h3, 128'hFD, 128'h1};
    vecs[1].exp[M_CBCE] = {{16{8'hA5}}, 128'h3, 128'h2, 128'h1};
    vecs[1].exp[M_CBCD] = {{16{8'hA5}}, 128'h3, 128'h2, 128'h1};
    vecs[1].fbiv = {16{8'hA5}};

    vecs[2].c  = {128'd4, 128'd3, 128'd2, 128'd1};
    vecs[2].d  = '0;
    vecs[2].ch = {128'd1, 128'd1, 128'd1, 128'd1};
    vecs[2].k  = 64'h0000_0000_0000_00FF;
    vecs[2].l  = 1'b0;
    vecs[2].exp[M_ECB]  = {128'd4, 128'd3, 128'd2, 128'd1};
    vecs[2].exp[M_CTR]  = {128'd4, 128'd3, 128'd2, 128'd1};
    vecs[2].exp[M_CBCE] = {128'd4, 128'd3, 128'd2, 128'd1};
    vecs[2].exp[M_CBCD] = {128'd5, 128'd2, 128'd3, 128'd0};
    vecs[2].fbiv = 128'd4;

    vecs[3].c  = {4{128'h0123456789ABCDEF_FEDCBA9876543210}};
    vecs[3].d  = {DW{1'b1}};
    vecs[3].ch = {4{128'h0123456789ABCDEF_FEDCBA9876543210}};
    vecs[3].k  = 64'hA5A5_0000_FFFF_1234;
    vecs[3].l  = 1'b1;
    vecs[3].exp[M_ECB]  = {4{128'h0123456789ABCDEF_FEDCBA9876543210}};
    vecs[3].exp[M_CTR]  = {4{128'hFEDCBA9876543210_0123456789ABCDEF}};
    vecs[3].exp[M_CBCE] = {4{128'h0123456789ABCDEF_FEDCBA9876543210}};
    vecs[3].exp[M_CBCD] = '0;
    vecs[3].fbiv = 128'h0123456789ABCDEF_FEDCBA9876543210;

    // ---------------- reset state ----------------
    rst    = 1'b1;
    iready = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_ovalid_m%0d", m),  ovalid_a[m],  '0);
      chk($sformatf("rst_odata_m%0d", m),   odata_a[m],   '0);
      chk($sformatf("rst_okeep_m%0d", m),   okeep_a[m],   '0);
      chk($sformatf("rst_olast_m%0d", m),   olast_a[m],   '0);
      chk($sformatf("rst_af_m%0d", m),      oaf_a[m],     '0);
      chk($sformatf("rst_ovf_m%0d", m),     oovf_a[m],    '0);
      chk($sformatf("rst_oblocks_m%0d", m), oblocks_a[m], '0);
      chk($sformatf("rst_fbv_m%0d", m),     ofbv_a[m],    '0);
      chk($sformatf("rst_fbiv_m%0d", m),    ofbiv_a[m],   '0);
    end
    exp_blocks = 0;

    // ---------------- table-driven datapath ----------------
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].c, vecs[v].d, vecs[v].ch, vecs[v].k, vecs[v].l);
      step();
      idle();
      // T+1: feedback strobe only, no output yet
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("vec%0d_t1_fbv_m%0d", v, m), ofbv_a[m], (m == M_CBCE) ? 1'b1 : 1'b0);
        chk($sformatf("vec%0d_t1_fbiv_m%0d", v, m), ofbiv_a[m],
            (m == M_CBCE) ? vecs[v].fbiv : 128'd0);
        chk($sformatf("vec%0d_t1_ovalid_m%0d", v, m), ovalid_a[m], '0);
      end
      step();
      // T+2: result visible, strobe gone
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("vec%0d_ovalid_m%0d", v, m), ovalid_a[m], 1'b1);
        chk($sformatf("vec%0d_odata_m%0d", v, m),  odata_a[m],  vecs[v].exp[m]);
        chk($sformatf("vec%0d_okeep_m%0d", v, m),  okeep_a[m],  vecs[v].k);
        chk($sformatf("vec%0d_olast_m%0d", v, m),  olast_a[m],  vecs[v].l);
        chk($sformatf("vec%0d_t2_fbv_m%0d", v, m), ofbv_a[m],   '0);
      end
      step();
      exp_blocks++;
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("vec%0d_oblocks_m%0d", v, m), oblocks_a[m], 32'(exp_blocks));
        chk($sformatf("vec%0d_drained_m%0d", v, m), ovalid_a[m], '0);
      end
    end

    // ---------------- almost-full and overflow ----------------
    iready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_idx(i);
      step();
    end
    idle();
    step();
    chk("af_at_16_same_cycle", oaf_a[M_ECB], 1'b0);
    step();
    chk("af_at_16_next_cycle", oaf_a[M_ECB], 1'b1);
    for (int i = 16; i < 32; i++) begin
      send_idx(i);
      step();
    end
    idle();
    step();
    step();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("full32_ovf_m%0d", m), oovf_a[m], 1'b0);
    end
    send_idx(32);
    step();
    idle();
    step();
    step();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("word33_ovf_m%0d", m), oovf_a[m], 1'b1);
    end
    iready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("drain%0d_ovalid", i), ovalid_a[M_ECB], 1'b1);
      chk($sformatf("drain%0d_odata", i),  odata_a[M_ECB],  {384'd0, 128'(i)});
      chk($sformatf("drain%0d_olast", i),  olast_a[M_ECB],  ((i % 2) == 1));
      step();
    end
    exp_blocks += 32;
    chk("dropped_word_absent", ovalid_a[M_ECB], 1'b0);
    chk("drain_oblocks", oblocks_a[M_ECB], 32'(exp_blocks));
    chk("drain_ovf_sticky", oovf_a[M_ECB], 1'b1);
    step();
    chk("drain_af_clear", oaf_a[M_ECB], 1'b0);

    // ---------------- reset mid-stream ----------------
    iready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_idx(200 + i);
      step();
    end
    idle();
    step();
    step();
    chk("pre_rst_ovalid", ovalid_a[M_ECB], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("midrst_ovalid_m%0d", m),  ovalid_a[m],  '0);
      chk($sformatf("midrst_oblocks_m%0d", m), oblocks_a[m], '0);
      chk($sformatf("midrst_ovf_m%0d", m),     oovf_a[m],    '0);
      chk($sformatf("midrst_af_m%0d", m),      oaf_a[m],     '0);
    end
    step();
    rst = 1'b0;
    exp_blocks = 0;
    iready = 1'b1;
    send_idx(7);
    step();
    idle();
    chk("postrst_t1_ovalid", ovalid_a[M_ECB], 1'b0);
    step();
    chk("postrst_t2_ovalid", ovalid_a[M_ECB], 1'b1);
    chk("postrst_t2_odata",  odata_a[M_ECB],  {384'd0, 128'd7});
    step();
    exp_blocks++;
    chk("postrst_oblocks", oblocks_a[M_ECB], 32'(exp_blocks));
    chk("postrst_empty",   ovalid_a[M_ECB], 1'b0);

    // ---------------- full FIFO with pop and write every cycle ----------------
    // Word k is written at the end of cycle k+1, so the FIFO is full from
    // cycle 33 on; ready rises exactly then, so each of the next 40 cycles
    // pops and writes at full occupancy.
    rd_idx = 0;
    for (int cyc = 0; cyc <= 72; cyc++) begin
      iready = (cyc >= 33);
      send_idx(cyc);
      if (iready) begin
        chk($sformatf("stream%0d_ovalid", cyc), ovalid_a[M_ECB], 1'b1);
        chk($sformatf("stream%0d_odata", cyc),  odata_a[M_ECB],  {384'd0, 128'(rd_idx)});
        rd_idx++;
      end
      step();
    end
    idle();
    exp_blocks += 40;
    chk("stream_oblocks_plus40", oblocks_a[M_ECB], 32'(exp_blocks));
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("stream_ovf_m%0d", m), oovf_a[m], 1'b0);
    end
    for (int n = 0; n < 40 && ovalid_a[M_ECB]; n++) begin
      chk($sformatf("tail%0d_odata", n), odata_a[M_ECB], {384'd0, 128'(rd_idx)});
      chk($sformatf("tail%0d_cbcd", n),  odata_a[M_CBCD], {384'd0, 128'(rd_idx)});
      rd_idx++;
      step();
    end
    chk("stream_total_words", 512'(rd_idx), 512'd73);
    chk("stream_final_empty", ovalid_a[M_ECB], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
